// File: rtl/axi4_lite_slave_regfile.sv
// axi4_lite_slave_regfile: AXI4-Lite slave exposing NUM_REGS byte-strobed 32-bit registers
module axi4_lite_slave_regfile #(
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = 32
) (
   input  logic              i_aclk,
   input  logic              i_areset,
   input  logic [ADDR_W-1:0] i_awaddr,
   input  logic              i_awvalid,
   output logic              o_awready,
   input  logic [31:0]       i_wdata,
   input  logic [3:0]        i_wstrb,
   input  logic              i_wvalid,
   output logic              o_wready,
   output logic [1:0]        o_bresp,
   output logic              o_bvalid,
   input  logic              i_bready,
   input  logic [ADDR_W-1:0] i_araddr,
   input  logic              i_arvalid,
   output logic              o_arready,
   output logic [31:0]       o_rdata,
   output logic [1:0]        o_rresp,
   output logic              o_rvalid,
   input  logic              i_rready
);
   localparam int IDX_W = $clog2(NUM_REGS);
   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;
   w_state_t          r_wstate;
   r_state_t          r_rstate;
   logic [31:0]       r_regs [NUM_REGS];
   logic [ADDR_W-1:0] r_awaddr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_wstrb;
   logic              r_have_aw;
   logic              r_have_w;
   logic              w_aw_hs;
   logic              w_w_hs;
   logic              w_ar_hs;
   logic              w_commit;
   logic [ADDR_W-1:0] w_waddr;
   logic [31:0]       w_wdata;
   logic [3:0]        w_wstrb;
   logic              w_wr_ok;
   logic              w_rd_ok;
   logic [IDX_W-1:0]  w_widx;
   logic [IDX_W-1:0]  w_ridx;
   // A channel captured on this very edge is used directly, so commit needs no extra cycle
   always_comb begin
      w_aw_hs  = i_awvalid && o_awready;
      w_w_hs   = i_wvalid && o_wready;
      w_ar_hs  = i_arvalid && o_arready;
      w_waddr  = w_aw_hs ? i_awaddr : r_awaddr;
      w_wdata  = w_w_hs ? i_wdata : r_wdata;
      w_wstrb  = w_w_hs ? i_wstrb : r_wstrb;
      w_commit = (r_wstate == W_IDLE) && (r_have_aw || w_aw_hs) && (r_have_w || w_w_hs);
      w_wr_ok  = (w_waddr >> (IDX_W + 2)) == '0;
      w_rd_ok  = (i_araddr >> (IDX_W + 2)) == '0;
      w_widx   = w_waddr[IDX_W+1:2];
      w_ridx   = i_araddr[IDX_W+1:2];
   end
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         r_wstate  <= W_IDLE;
         o_awready <= 1'b0;
         o_wready  <= 1'b0;
         o_bvalid  <= 1'b0;
         o_bresp   <= 2'b00;
         r_have_aw <= 1'b0;
         r_have_w  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (r_wstate == W_IDLE) begin
         if (w_aw_hs) begin
            r_awaddr  <= i_awaddr;
            r_have_aw <= 1'b1;
         end
         if (w_w_hs) begin
            r_wdata  <= i_wdata;
            r_wstrb  <= i_wstrb;
            r_have_w <= 1'b1;
         end
         if (w_commit) begin
            if (w_wr_ok)
               for (int b = 0; b < 4; b++)
                  if (w_wstrb[b]) r_regs[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
            o_bresp   <= w_wr_ok ? 2'b00 : 2'b10;
            o_bvalid  <= 1'b1;
            o_awready <= 1'b0;
            o_wready  <= 1'b0;
            r_wstate  <= W_RESP;
         end else begin
            o_awready <= !(r_have_aw || w_aw_hs);
            o_wready  <= !(r_have_w || w_w_hs);
         end
      end else if (i_bready) begin
         o_bvalid  <= 1'b0;
         r_have_aw <= 1'b0;
         r_have_w  <= 1'b0;
         o_awready <= 1'b1;
         o_wready  <= 1'b1;
         r_wstate  <= W_IDLE;
      end
   end
   // Reads sample r_regs before any same-edge write lands, giving the pre-write value
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         r_rstate  <= R_IDLE;
         o_arready <= 1'b0;
         o_rvalid  <= 1'b0;
         o_rdata   <= '0;
         o_rresp   <= 2'b00;
      end else if (r_rstate == R_IDLE) begin
         o_arready <= !w_ar_hs;
         if (w_ar_hs) begin
            o_rdata  <= w_rd_ok ? r_regs[w_ridx] : 32'h0;
            o_rresp  <= w_rd_ok ? 2'b00 : 2'b10;
            o_rvalid <= 1'b1;
            r_rstate <= R_DATA;
         end
      end else if (i_rready) begin
         o_rvalid  <= 1'b0;
         o_arready <= 1'b1;
         r_rstate  <= R_IDLE;
      end
   end
endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// tb_axi4_lite_slave_regfile: directed AXI4-Lite traffic checked against a register-array model
module tb_axi4_lite_slave_regfile;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
   logic [3:0]  wstrb = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   int          checks = 0, passed = 0;
   logic [31:0] mregs [16];
   logic [1:0]  bq [$];
   logic [33:0] rq [$];
   always #5 clk = ~clk;
   axi4_lite_slave_regfile dut (
      .i_aclk(clk), .i_areset(rst),
      .i_awaddr(awaddr), .i_awvalid(awvalid), .o_awready(awready),
      .i_wdata(wdata), .i_wstrb(wstrb), .i_wvalid(wvalid), .o_wready(wready),
      .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
      .i_araddr(araddr), .i_arvalid(arvalid), .o_arready(arready),
      .o_rdata(rdata), .o_rresp(rresp), .o_rvalid(rvalid), .i_rready(rready)
   );
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", n, act, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // Every cycle a response is valid it must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (bvalid) begin
         if (bq.size() == 0) chk("bvalid_spurious", 32'(bvalid), 32'h0);
         else chk("bresp", 32'(bresp), 32'(bq[0]));
      end
      if (rvalid) begin
         if (rq.size() == 0) chk("rvalid_spurious", 32'(rvalid), 32'h0);
         else begin
            chk("rdata", rdata, rq[0][31:0]);
            chk("rresp", 32'(rresp), 32'(rq[0][33:32]));
         end
      end
   end
   always @(posedge clk) begin
      if (bvalid && bready && bq.size() != 0) bq.delete(0);
      if (rvalid && rready && rq.size() != 0) rq.delete(0);
   end
   // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int hold);
      logic [31:0] m;
      logic hs_aw, hs_w, hs_b;
      bit got_aw = 0, got_w = 0;
      int n = 0;
      int la = lead > 0 ? lead : 0;
      int lw = lead < 0 ? -lead : 0;
      m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      if (a < 64) begin
         mregs[a[5:2]] = (mregs[a[5:2]] & ~m) | (d & m);
         bq.push_back(2'b00);
      end else bq.push_back(2'b10);
      while (!(got_aw && got_w) && n < 50) begin
         if (!got_aw && !awvalid && n >= la) begin awaddr = a; awvalid = 1'b1; end
         if (!got_w && !wvalid && n >= lw) begin wdata = d; wstrb = s; wvalid = 1'b1; end
         @(negedge clk);
         hs_aw = awvalid && awready;
         hs_w  = wvalid && wready;
         tick();
         n++;
         if (hs_aw) begin awvalid = 1'b0; got_aw = 1; chk("awready_drop", 32'(awready), 32'h0); end
         if (hs_w) begin wvalid = 1'b0; got_w = 1; chk("wready_drop", 32'(wready), 32'h0); end
         if (got_aw != got_w) chk("b_waits_both", 32'(bvalid), 32'h0);
      end
      if (!(got_aw && got_w)) chk("write_hs_timeout", 32'h0, 32'h1);
      chk("bvalid_lat", 32'(bvalid), 32'h1);
      repeat (hold) begin
         tick();
         chk("bvalid_hold", 32'(bvalid), 32'h1);
         chk("awready_hold", 32'(awready), 32'h0);
         chk("wready_hold", 32'(wready), 32'h0);
      end
      bready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         hs_b = bvalid && bready;
         tick();
         n++;
      end while (!hs_b && n < 50);
      bready = 1'b0;
      if (!hs_b) chk("b_hs_timeout", 32'h0, 32'h1);
      chk("bvalid_clear", 32'(bvalid), 32'h0);
      chk("awready_back", 32'(awready), 32'h1);
      chk("wready_back", 32'(wready), 32'h1);
   endtask
   task automatic start_read(input logic [31:0] a, input bit lit, input logic [31:0] ld,
                             input logic [1:0] lr);
      logic hs;
      int n = 0;
      if (lit) rq.push_back({lr, ld});
      else rq.push_back(a < 64 ? {2'b00, mregs[a[5:2]]} : {2'b10, 32'h0});
      araddr = a;
      arvalid = 1'b1;
      do begin
         @(negedge clk);
         hs = arvalid && arready;
         tick();
         n++;
      end while (!hs && n < 50);
      arvalid = 1'b0;
      if (!hs) chk("ar_hs_timeout", 32'h0, 32'h1);
      chk("rvalid_lat", 32'(rvalid), 32'h1);
      chk("arready_busy", 32'(arready), 32'h0);
   endtask
   task automatic do_read(input logic [31:0] a, input int hold, input bit lit,
                          input logic [31:0] ld, input logic [1:0] lr);
      logic hs;
      int n = 0;
      start_read(a, lit, ld, lr);
      repeat (hold) tick();
      rready = 1'b1;
      do begin
         @(negedge clk);
         hs = rvalid && rready;
         tick();
         n++;
      end while (!hs && n < 50);
      rready = 1'b0;
      if (!hs) chk("r_hs_timeout", 32'h0, 32'h1);
      chk("rvalid_clear", 32'(rvalid), 32'h0);
      chk("arready_back", 32'(arready), 32'h1);
   endtask
   task automatic release_reset();
      tick();
      rst = 1'b0;
      chk("arready_pre", 32'(arready), 32'h0);
      tick();
      chk("arready_up", 32'(arready), 32'h1);
      chk("awready_up", 32'(awready), 32'h1);
      chk("wready_up", 32'(wready), 32'h1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      for (int i = 0; i < 16; i++) mregs[i] = '0;
      tick();
      tick();
      chk("rst_bvalid", 32'(bvalid), 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_awready", 32'(awready), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      release_reset();
      do_read(32'h0, 0, 1, 32'h0, 2'b00);
      do_write(32'h7, 32'h0DEADBEE, 4'hF, 0, 0);
      do_read(32'h4, 0, 1, 32'h0DEADBEE, 2'b00);
      do_read(32'h7, 0, 1, 32'h0DEADBEE, 2'b00);
      do_write(32'h7, 32'h0DEADBE0, 4'hF, 3, 0);
      do_read(32'h7, 0, 1, 32'h0DEADBE0, 2'b00);
      do_write(32'h8, 32'h11223344, 4'hF, 0, 0);
      do_write(32'h8, 32'hAABBCCDD, 4'b0101, 0, 0);
      do_read(32'h8, 0, 1, 32'h11BB33DD, 2'b00);
      chk("model_strobe", mregs[2], 32'h11BB33DD);
      do_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0);
      do_read(32'h40, 0, 1, 32'h0, 2'b10);
      do_read(32'h4, 0, 0, 32'h0, 2'b00);
      do_read(32'h8, 0, 0, 32'h0, 2'b00);
      do_write(32'hC, 32'h12345678, 4'h0, 0, 0);
      do_read(32'hC, 0, 1, 32'h0, 2'b00);
      do_write(32'h3C, 32'hCAFEF00D, 4'hF, 0, 0);
      do_read(32'h3F, 2, 1, 32'hCAFEF00D, 2'b00);
      do_write(32'h14, 32'h55AA55AA, 4'hF, -2, 5);
      do_read(32'h14, 0, 0, 32'h0, 2'b00);
      do_write(32'h10, 32'h01020304, 4'hF, 0, 0);
      fork
         do_write(32'h10, 32'hA0B0C0D0, 4'hF, 0, 0);
         do_read(32'h10, 0, 1, 32'h01020304, 2'b00);
      join
      do_read(32'h10, 0, 1, 32'hA0B0C0D0, 2'b00);
      start_read(32'h4, 0, 32'h0, 2'b00);
      tick();
      #2;
      rst = 1'b1;
      rq.delete();
      bq.delete();
      for (int i = 0; i < 16; i++) mregs[i] = '0;
      #1;
      chk("midrst_rvalid", 32'(rvalid), 32'h0);
      chk("midrst_arready", 32'(arready), 32'h0);
      chk("midrst_rdata", rdata, 32'h0);
      tick();
      release_reset();
      for (int i = 0; i < 16; i++) do_read(32'(i * 4), 0, 0, 32'h0, 2'b00);
      do_read(32'h3C, 0, 1, 32'h0, 2'b00);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/axi4_lite_slave_regfile.md
# axi4_lite_slave_regfile

AXI4-Lite responder holding a bank of 32-bit software-visible registers; it is the slave end that the AXI4-Lite master in `axi4_lite_top` talks to. It accepts write address and write data on independent channels in any order, applies byte strobes, and returns OKAY or SLVERR. Reads return registered data one cycle after the address handshake. Read and write paths are fully independent state machines.

## Interface
- NUM_REGS, 16, number of 32-bit registers (power of two, 2..256)
- ADDR_W, 32, address bus width
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- AWADDR  in  ADDR_W  write address
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  32  write data
- WSTRB  in  4  byte enables, bit i gates WDATA[8i+7:8i]
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BRESP  out  2  write response, 2'b00 OKAY, 2'b10 SLVERR
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- ARADDR  in  ADDR_W  read address
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  32  read data
- RRESP  out  2  read response, same encoding as BRESP
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready

## Operation
- Decode: word index = addr[log2(NUM_REGS)+1:2]; addr[1:0] ignored (0x7 maps to register 1). Address >= NUM_REGS*4 is out of range.
- Write FSM, states W_IDLE, W_RESP.
  - In W_IDLE: AWREADY=1 until AW captured, WREADY=1 until W captured; each channel latched independently into a holding register plus a "have" flag.
  - When both address and data are held (either captured this edge or earlier), commit on that edge: in range -> update enabled bytes per WSTRB, BRESP=OKAY; out of range -> no register changes, BRESP=SLVERR. Go to W_RESP, BVALID=1, AWREADY=WREADY=0.
  - W_RESP: hold BVALID/BRESP stable until BVALID&&BREADY; on that edge BVALID=0, clear flags, AWREADY=WREADY=1, return to W_IDLE.
  - WSTRB=4'b0000 in range: OKAY, register unchanged.
- Read FSM, states R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On ARVALID&&ARREADY: RDATA = register contents (in range, RRESP=OKAY) or 32'h0 (out of range, RRESP=SLVERR); RVALID=1, ARREADY=0, go R_DATA.
  - R_DATA: RDATA/RRESP/RVALID stable until RVALID&&RREADY; then RVALID=0, ARREADY=1, back to R_IDLE.
- Simultaneous read and write to same register on same edge: read returns the pre-write value.
- Only one outstanding transaction per channel pair; no ID, no pipelining.

## Timing
- ARESET high (async): all registers 0, BVALID=0, RVALID=0, BRESP=RRESP=0, RDATA=0, AWREADY=WREADY=ARREADY=0, flags cleared, FSMs idle.
- First rising edge after ARESET deasserts: AWREADY, WREADY, ARREADY go to 1.
- Write latency: BVALID asserted in the cycle after the edge on which the later of AW/W handshakes completes; register new value visible to a read issued on that same following cycle.
- Read latency: RVALID asserted in the cycle after the AR handshake edge.
- Back-to-back: with BREADY/RREADY held high, a new transaction is accepted every 2 cycles per direction.
- ARESET asserted mid-transaction: transaction dropped, no response, state as per reset.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset then read 0x0 -> RVALID one cycle after AR handshake, RDATA=0x0, RRESP=OKAY.
- AW=0x7 and W=0x0DEADBEE, WSTRB=4'hF in same cycle, BREADY=1 -> BVALID next cycle BRESP=OKAY; read 0x4 and 0x7 both return 0x0DEADBEE.
- W (0x0DEADBE0) presented 3 cycles before AW (0x7) -> WREADY drops after W handshake, commit only on AW handshake, read 0x7 returns 0x0DEADBE0.
- Register 2 = 0x11223344, write 0xAABBCCDD with WSTRB=4'b0101 -> read 0x8 returns 0x11BB33DD.
- Write to 0x40 (NUM_REGS=16) -> BRESP=SLVERR, no register changes; read 0x40 -> RDATA=0, RRESP=SLVERR.
- Hold BREADY=0 for 5 cycles -> BVALID/BRESP stable, AWREADY/WREADY stay 0; pulse ARESET during R_DATA -> RVALID=0 immediately, all registers read back 0.
